// File: rtl/rcpu_gpio_bank.sv
// rcpu_gpio_bank: parametrised GPIO bank on the RCPU IO bus.
// Registers: DATA, DIR, SET, CLR, TGL, IRQ_EN, PEND (W1C), EDGE.
// Inputs pass through a synchroniser, then feed edge detection and DATA reads.
// Edge detection sets sticky pending flags, and the enabled flags drive a level irq.
// Optional macro GPIO_DEBOUNCE_EN places a per-bit stability counter after the synchroniser.
module rcpu_gpio_bank #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_sel,
  input  logic [2:0]       io_reg,
  input  logic             io_read_enable,
  input  logic             io_write_enable,
  input  logic [0:15]      io_write_data,
  output logic [0:15]      io_read_data,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] pin_out,
  output logic [WIDTH-1:0] pin_oe,
  output logic             irq
);

  typedef enum logic [2:0] {
    REG_DATA   = 3'd0,
    REG_DIR    = 3'd1,
    REG_SET    = 3'd2,
    REG_CLR    = 3'd3,
    REG_TGL    = 3'd4,
    REG_IRQ_EN = 3'd5,
    REG_PEND   = 3'd6,
    REG_EDGE   = 3'd7
  } gpio_reg_e;

  localparam int PRIME = SYNC_STAGES + 1;

  gpio_reg_e        reg_sel;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] out_reg;
  logic [WIDTH-1:0] dir_reg;
  logic [WIDTH-1:0] irq_en;
  logic [WIDTH-1:0] edge_pol;
  logic [WIDTH-1:0] pend;
  logic [WIDTH-1:0] pend_clr;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] in_val;
  logic [WIDTH-1:0] prev_in;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] rd_vec;
  logic [0:15]      rd_bus;
  logic [2:0]       prime_cnt;
  logic             armed;
  logic             unused_wd;

  assign reg_sel   = gpio_reg_e'(io_reg);
  assign wr_en     = io_write_enable & io_sel;
  assign rd_en     = io_read_enable & io_sel;
  assign pin_out   = out_reg;
  assign pin_oe    = dir_reg;
  assign sync_in   = sync_q[SYNC_STAGES-1];
  assign armed     = (prime_cnt == 3'(PRIME));
  assign unused_wd = ^io_write_data;

  // GPIO bit i sits on bus bit 15-i; upper bus bits read back as zero.
  always_comb begin
    wd     = '0;
    rd_bus = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      wd[i]        = io_write_data[15-i];
      rd_bus[15-i] = rd_vec[i];
    end
  end

  // Input synchroniser chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= pin_in;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic [15:0]      db_cnt [WIDTH];
  logic [WIDTH-1:0] db_val;

  // Debounce: flip a bit only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_val <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) db_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (sync_in[i] != db_val[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            db_val[i] <= sync_in[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 16'd1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign in_val = db_val;
`else
  logic unused_db;
  assign unused_db = (DEBOUNCE_CYCLES != 0);
  assign in_val    = sync_in;
`endif

  // Per-bit edge select; suppressed until the synchroniser has primed after reset.
  always_comb begin
    edge_det = '0;
    if (armed) begin
      edge_det = (edge_pol & in_val & ~prev_in) | (~edge_pol & ~in_val & prev_in);
    end
  end

  // Previous-sample register and start-up blanking counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_in   <= '0;
      prime_cnt <= '0;
    end else begin
      prev_in <= in_val;
      if (!armed) prime_cnt <= prime_cnt + 3'd1;
    end
  end

  assign pend_clr = (wr_en && reg_sel == REG_PEND) ? wd : '0;

  // Control registers, sticky pending flags (set beats W1C) and registered irq.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_reg  <= '0;
      dir_reg  <= '0;
      irq_en   <= '0;
      edge_pol <= '0;
      pend     <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr_en) begin
        case (reg_sel)
          REG_DATA:   out_reg  <= wd;
          REG_DIR:    dir_reg  <= wd;
          REG_SET:    out_reg  <= out_reg | wd;
          REG_CLR:    out_reg  <= out_reg & ~wd;
          REG_TGL:    out_reg  <= out_reg ^ wd;
          REG_IRQ_EN: irq_en   <= wd;
          REG_EDGE:   edge_pol <= wd;
          default:    ;
        endcase
      end
      pend <= (pend & ~pend_clr) | edge_det;
      irq  <= |(pend & irq_en);
    end
  end

  // Read mux; write-only registers read back out_reg.
  always_comb begin
    rd_vec = '0;
    case (reg_sel)
      REG_DATA:   rd_vec = in_val;
      REG_DIR:    rd_vec = dir_reg;
      REG_IRQ_EN: rd_vec = irq_en;
      REG_PEND:   rd_vec = pend;
      REG_EDGE:   rd_vec = edge_pol;
      default:    rd_vec = out_reg;
    endcase
  end

  // Registered read data with one-cycle latency; holds between reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io_read_data <= '0;
    end else if (rd_en) begin
      io_read_data <= rd_bus;
    end
  end

endmodule

// File: tb/tb_rcpu_gpio_bank.sv
// Directed bench for rcpu_gpio_bank: WIDTH=8 main instance plus a WIDTH=3 instance.
// Read expectations are queued when a read is issued and checked when data returns.
module tb_rcpu_gpio_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        io_sel;
  logic [2:0]  io_reg;
  logic        io_read_enable;
  logic        io_write_enable;
  logic [0:15] io_write_data;
  logic [0:15] rdata8;
  logic [0:15] rdata3;
  logic [7:0]  pin_in8;
  logic [7:0]  pin_out8;
  logic [7:0]  pin_oe8;
  logic        irq8;
  logic [2:0]  pin_in3;
  logic [2:0]  pin_out3;
  logic [2:0]  pin_oe3;
  logic        irq3;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    string       tag;
    logic [15:0] exp;
    bit          unit3;
  } rd_exp_t;

  rd_exp_t sb[$];

  rcpu_gpio_bank #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16)) u_dut (
    .clk(clk), .reset(reset), .io_sel(io_sel), .io_reg(io_reg),
    .io_read_enable(io_read_enable), .io_write_enable(io_write_enable),
    .io_write_data(io_write_data), .io_read_data(rdata8),
    .pin_in(pin_in8), .pin_out(pin_out8), .pin_oe(pin_oe8), .irq(irq8)
  );

  rcpu_gpio_bank #(.WIDTH(3), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16)) u_dut3 (
    .clk(clk), .reset(reset), .io_sel(io_sel), .io_reg(io_reg),
    .io_read_enable(io_read_enable), .io_write_enable(io_write_enable),
    .io_write_data(io_write_data), .io_read_data(rdata3),
    .pin_in(pin_in3), .pin_out(pin_out3), .pin_oe(pin_oe3), .irq(irq3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] r, input logic [15:0] d);
    io_sel = 1'b1; io_reg = r; io_write_data = d; io_write_enable = 1'b1;
    cyc();
    io_write_enable = 1'b0; io_sel = 1'b0;
  endtask

  task automatic pop_check();
    rd_exp_t e;
    if (sb.size() == 0) begin
      chk("sb_underflow", 16'h0001, 16'h0000);
    end else begin
      e = sb.pop_front();
      chk(e.tag, e.unit3 ? rdata3 : rdata8, e.exp);
    end
  endtask

  task automatic rd(input logic [2:0] r, input logic [15:0] exp, input string tag,
                    input bit u3 = 1'b0);
    sb.push_back('{tag: tag, exp: exp, unit3: u3});
    io_sel = 1'b1; io_reg = r; io_read_enable = 1'b1;
    cyc();
    io_read_enable = 1'b0; io_sel = 1'b0;
    pop_check();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; io_sel = 1'b0; io_reg = '0; io_read_enable = 1'b0;
    io_write_enable = 1'b0; io_write_data = '0;
    pin_in8 = 8'hFF; pin_in3 = 3'b111;

    // Reset state, with pins held high through reset release
    repeat (3) cyc();
    chk("rst_pin_out", pin_out8, 16'h0000);
    chk("rst_pin_oe", pin_oe8, 16'h0000);
    chk("rst_irq", irq8, 16'h0000);
    chk("rst_rdata", rdata8, 16'h0000);
    reset = 1'b0;

    // Start-up blanking: rising-edge select armed on the first edge after release
    wr(3'd7, 16'h00FF);
    repeat (100) cyc();
    rd(3'd6, 16'h0000, "blank_pend");
    rd(3'd7, 16'h00FF, "edge_rd");
    pin_in8 = 8'h00;
    repeat (5) cyc();
    rd(3'd6, 16'h0000, "fall_no_pend");
    rd(3'd0, 16'h0000, "data_zero");

    // Bit-manipulation writes
    wr(3'd1, 16'h00FF); chk("dir_oe", pin_oe8, 16'h00FF);
    wr(3'd0, 16'h00A5); chk("data_out", pin_out8, 16'h00A5);
    wr(3'd2, 16'h0002); chk("set_out", pin_out8, 16'h00A7);
    wr(3'd3, 16'h0080); chk("clr_out", pin_out8, 16'h0027);
    wr(3'd4, 16'h000F); chk("tgl_out", pin_out8, 16'h0028);
    rd(3'd2, 16'h0028, "rd_wo_reg");
    rd(3'd1, 16'h00FF, "rd_dir");

    // Same-cycle read and write of DIR returns the pre-write value
    sb.push_back('{tag: "rdwr_old", exp: 16'h00FF, unit3: 1'b0});
    io_sel = 1'b1; io_reg = 3'd1; io_write_data = 16'h000F;
    io_write_enable = 1'b1; io_read_enable = 1'b1;
    cyc();
    io_write_enable = 1'b0; io_read_enable = 1'b0; io_sel = 1'b0;
    pop_check();
    chk("rdwr_oe", pin_oe8, 16'h000F);
    rd(3'd1, 16'h000F, "rdwr_new");

    // Rising-edge interrupt on bit 0
    wr(3'd7, 16'h0001);
    wr(3'd5, 16'h0001);
    pin_in8 = 8'h01;
    cyc(); cyc();
    rd(3'd6, 16'h0000, "pend_before");
    chk("irq_before", irq8, 16'h0000);
    rd(3'd6, 16'h0001, "pend_set");
    chk("irq_set", irq8, 16'h0001);
    wr(3'd6, 16'h0001);
    chk("irq_w1c_lag", irq8, 16'h0001);
    cyc();
    chk("irq_w1c_low", irq8, 16'h0000);
    rd(3'd6, 16'h0000, "pend_w1c");

    // W1C in the same cycle as a new edge: set wins
    pin_in8 = 8'h00;
    repeat (4) cyc();
    pin_in8 = 8'h01;
    cyc(); cyc();
    wr(3'd6, 16'h0001);
    cyc();
    chk("irq_collide", irq8, 16'h0001);
    // Clearing irq_en drops irq a cycle later but keeps pend
    wr(3'd5, 16'h0000);
    chk("irq_en_lag", irq8, 16'h0001);
    cyc();
    chk("irq_en_low", irq8, 16'h0000);
    rd(3'd6, 16'h0001, "pend_collide");
    wr(3'd6, 16'h0001);
    rd(3'd6, 16'h0000, "pend_clr2");

    // DATA reads show synchronised pins
    pin_in8 = 8'h5A;
    repeat (3) cyc();
    rd(3'd0, 16'h005A, "data_pins");
    rd(3'd6, 16'h0000, "pend_no_edge");

    // WIDTH=3 mapping
    wr(3'd0, 16'hFFFF);
    chk("w3_pin_out", pin_out3, 16'h0007);
    chk("w8_pin_out", pin_out8, 16'h00FF);
    rd(3'd0, 16'h0007, "w3_data_rd", 1'b1);
    rd(3'd2, 16'h0007, "w3_out_rd", 1'b1);

    // Asynchronous reset mid-operation
    reset = 1'b1;
    #1;
    chk("arst_pin_out", pin_out8, 16'h0000);
    chk("arst_pin_oe", pin_oe8, 16'h0000);
    chk("arst_rdata", rdata8, 16'h0000);
    cyc();
    reset = 1'b0;
    rd(3'd1, 16'h0000, "arst_dir");

`ifdef GPIO_DEBOUNCE_EN
    // Debounced input with DEBOUNCE_CYCLES=16
    pin_in8 = 8'h00;
    wr(3'd7, 16'h0001);
    repeat (30) cyc();
    wr(3'd6, 16'h00FF);
    pin_in8 = 8'h01;
    repeat (10) cyc();
    pin_in8 = 8'h00;
    repeat (20) cyc();
    rd(3'd0, 16'h0000, "db_glitch_data");
    rd(3'd6, 16'h0000, "db_glitch_pend");
    pin_in8 = 8'h01;
    repeat (25) cyc();
    rd(3'd0, 16'h0001, "db_hold_data");
    rd(3'd6, 16'h0001, "db_hold_pend");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rcpu_gpio_bank.md
Name: rcpu_gpio_bank

Overview:
- Parametrised GPIO bank for the RCPU IO bus; successor to the fixed 8-bit PMOD/HDR ports.
- Adds:
  - configurable width and input synchroniser depth;
  - atomic set, clear and toggle writes;
  - per-bit edge detection with sticky pending flags and a level interrupt output.
- Sits behind one one-hot io_address bit in top.
- Pad primitives (SB_IO) stay outside; this block drives pin_out/pin_oe and samples pin_in.

Parameters:
- WIDTH, 8, number of GPIO bits; legal 1..16.
- SYNC_STAGES, 2, input synchroniser flops; legal 2..4.
- DEBOUNCE_CYCLES, 1024, stable cycles required before a debounced input changes (only with GPIO_DEBOUNCE_EN); legal 2..65535.

Ports:
- clk  in  1  system clock (PLL output).
- reset  in  1  asynchronous, active-high reset.
- io_sel  in  1  decoded one-hot address bit for this bank.
- io_reg  in  3  register index (taken from low io_address bits by top).
- io_read_enable  in  1  CPU IO read strobe.
- io_write_enable  in  1  CPU IO write strobe.
- io_write_data  in  [0:15]  CPU write data, MSB-first numbering.
- io_read_data  out  [0:15]  registered read data.
- pin_in  in  WIDTH  raw pad inputs.
- pin_out  out  WIDTH  output data register.
- pin_oe  out  WIDTH  direction register; 1 = output.
- irq  out  1  OR of (pend & irq_en), registered.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high. Everything resets to 0:
  - out_reg, dir_reg, irq_en, edge_pol, pend;
  - synchroniser chain, io_read_data, irq.
- Bus bit mapping: GPIO bit i maps to io_write_data[15-i]. Reads are zero-extended in the upper 16-WIDTH bits.
- Register map (io_reg):
  - 0 DATA: read = synchronised pin state; write = out_reg.
  - 1 DIR: r/w dir_reg.
  - 2 SET: write-only; out_reg |= wd.
  - 3 CLR: write-only; out_reg &= ~wd.
  - 4 TGL: write-only; out_reg ^= wd.
  - 5 IRQ_EN: r/w.
  - 6 PEND: read pend; write-1-to-clear.
  - 7 EDGE: r/w edge_pol; 1 = rising, 0 = falling.
  - Reads of write-only registers (2, 3, 4) return out_reg.
- Write: takes effect on the clk edge where io_write_enable & io_sel. pin_out/pin_oe update the same edge. No other state changes on a write.
- Read: io_read_data is loaded on the edge where io_read_enable & io_sel, giving a 1-cycle latency. Otherwise io_read_data holds its value. Reads have no side effects.
- Synchroniser: pin_in passes through SYNC_STAGES flops to form sync_in. prev_in holds sync_in from the prior cycle.
- Edge detection:
  - edge[i] = edge_pol[i] ? (sync_in & ~prev_in) : (~sync_in & prev_in).
  - Edges are detected regardless of dir_reg (output pins loop back via pad input).
- Start-up blanking: a prime counter suppresses edge detection for SYNC_STAGES+1 cycles after reset deassertion. A pin high out of reset therefore never raises a spurious rising edge.
- Pending flags: pend[i] is set on edge[i] regardless of irq_en. It is cleared only by a PEND write with bit i = 1.
  - A W1C and a new edge on the same bit in the same cycle: set wins, pend stays 1.
- irq: registered, so it asserts 1 cycle after pend & irq_en becomes nonzero. Clearing irq_en deasserts irq 1 cycle later but leaves pend intact.
- Simultaneous read and write to the same register in one cycle: the read returns the pre-write value.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Blanking restarts when reset deasserts.

Optional Feature:
- Macro: GPIO_DEBOUNCE_EN.
- Defined:
  - Each bit has a 16-bit stability counter between sync_in and the edge/DATA path.
  - The debounced value changes only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any return to the old value restarts the counter from 0.
  - Debounced value and counters reset to 0.
  - Edge detection and DATA reads use the debounced value.
- Undefined: no counters; sync_in feeds DATA and edge logic directly; DEBOUNCE_CYCLES is ignored.

Test Plan:
- Bit-manipulation writes and readback, WIDTH=8:
  - stimulus: write DIR=0x00FF, DATA=0x00A5, SET=0x0002, CLR=0x0080, TGL=0x000F;
  - response: pin_oe=0xFF; pin_out goes 0xA5 -> 0xA7 -> 0x27 -> 0x28; read reg 2 returns 0x0028 one cycle after the strobe.
- Rising-edge interrupt:
  - stimulus: EDGE=0x01, IRQ_EN=0x01, pin_in[0] 0->1;
  - response: pend=0x01 after SYNC_STAGES+1 cycles; irq high 1 cycle later;
  - then: W1C PEND=0x01;
  - response: pend=0, irq low next cycle.
- W1C/edge collision:
  - stimulus: issue a PEND=0x01 write in the same cycle edge[0] fires;
  - response: pend[0] stays 1.
- Start-up blanking:
  - stimulus: hold pin_in=0xFF through reset release, EDGE=0xFF;
  - response: pend remains 0x00 for 100 cycles.
- WIDTH=3 mapping:
  - stimulus: write DATA=0xFFFF;
  - response: pin_out=3'b111; DATA read returns 0x0007 with pins=7, upper bits 0.
- GPIO_DEBOUNCE_EN, DEBOUNCE_CYCLES=16:
  - stimulus: 10-cycle glitch on pin_in[0];
  - response: no DATA change, no pend;
  - stimulus: hold the pin high for 20 cycles;
  - response: DATA bit 0 = 1 and pend[0] set after 16 stable cycles.
